muldiv_iter: RTL and testbench

Iterative, parametrised multiply/divide unit implementing the full RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for any `DATA_WIDTH`. It sits beside the single-cycle ALU in the execute stage. It replaces a purely combinational multiply and divide with a handshaked multi-cycle engine that:
- fits without wide DSP/divider inference;
- stalls the pipeline through `busy`.

---
 rtl/muldiv_pkg.sv | 45 ++++
 rtl/muldiv_iter_if.sv | 23 ++
 rtl/muldiv_iter_cond_negate.sv | 10 +
 rtl/muldiv_iter.sv | 179 +++++++++++++++++
 tb/tb_muldiv_iter.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state encodings and operand-class helpers for muldiv_iter
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } muldiv_state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_mul_high(input logic [2:0] op);
    return !op[2] && (op[1:0] != 2'b00);
  endfunction

  // MUL is treated as signed; its low half is the same either way
  function automatic logic is_signed1(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed2(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter_if.sv
// rtl/muldiv_iter_if.sv - request/response bundle between the execute stage and muldiv_iter
interface muldiv_iter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  abort;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] operand_1;
  logic [DATA_WIDTH-1:0] operand_2;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;

  modport master (
    output start, abort, op, operand_1, operand_2,
    input  busy, done, result
  );

  modport slave (
    input  start, abort, op, operand_1, operand_2,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_iter_cond_negate.sv
// rtl/muldiv_iter_cond_negate.sv - conditional two's-complement negation, wraps on most-negative
module cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = neg_i ? ((~x_i) + WIDTH'(1)) : x_i;
endmodule

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative RV32M multiply/divide engine; MULDIV_FAST_MUL_EN selects a
// single-cycle multiply path, divide stays radix-2 restoring.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_iter_if.slave bus
);
  localparam int W = DATA_WIDTH;

  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_PREP = ST_PREP;
  localparam logic [2:0] S_CALC = ST_CALC;
  localparam logic [2:0] S_FIX  = ST_FIX;
  localparam logic [2:0] S_DONE = ST_DONE;

  logic [2:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     m_q, m_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [W-1:0]     result_q, result_d;

  logic           sgn1, sgn2;
  logic [W-1:0]   mag1, mag2;
  logic           div_zero, div_ovf;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     rem_sh, rem_diff;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   div_sel, div_fix, fix_val;
  logic           div_neg;
  logic           accept;

  assign sgn1 = is_signed1(op_q) & a_q[W-1];
  assign sgn2 = is_signed2(op_q) & b_q[W-1];

  cond_negate #(.WIDTH(W)) u_mag1 (.x_i(a_q), .neg_i(sgn1), .y_o(mag1));
  cond_negate #(.WIDTH(W)) u_mag2 (.x_i(b_q), .neg_i(sgn2), .y_o(mag2));

  assign div_zero = (b_q == '0);
  assign div_ovf  = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
                    (a_q == {1'b1, {(W-1){1'b0}}}) && (b_q == '1);

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? m_q : {W{1'b0}})};
  assign mul_next = {mul_sum, acc_q[W-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient}, shifted left each step
  assign rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
  assign rem_diff = rem_sh - {1'b0, m_q};
  assign div_next = rem_diff[W] ? {rem_sh[W-1:0], acc_q[W-2:0], 1'b0}
                                : {rem_diff[W-1:0], acc_q[W-2:0], 1'b1};

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fast_prod;
  assign fast_prod = {{W{1'b0}}, mag1} * {{W{1'b0}}, mag2};
`endif

  cond_negate #(.WIDTH(2*W)) u_prod_fix (.x_i(acc_q), .neg_i(negq_q), .y_o(prod_fix));

  assign div_sel = is_rem(op_q) ? acc_q[2*W-1:W] : acc_q[W-1:0];
  assign div_neg = is_rem(op_q) ? negr_q : negq_q;

  cond_negate #(.WIDTH(W)) u_div_fix (.x_i(div_sel), .neg_i(div_neg), .y_o(div_fix));

  assign fix_val = is_div(op_q)      ? div_fix :
                   is_mul_high(op_q) ? prod_fix[2*W-1:W] : prod_fix[W-1:0];

  assign accept = bus.start && !bus.abort;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          op_d    = bus.op;
          a_d     = bus.operand_1;
          b_d     = bus.operand_2;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        negq_d  = sgn1 ^ sgn2;
        negr_d  = sgn1;
        m_d     = mag2;
        acc_d   = {{W{1'b0}}, mag1};
        cnt_d   = CNT_W'(W);
        state_d = S_CALC;
        if (is_div(op_q)) begin
          if (div_zero) begin
            acc_d   = {a_q, {W{1'b1}}};
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            state_d = S_FIX;
          end else if (div_ovf) begin
            acc_d   = {{W{1'b0}}, a_q};
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            state_d = S_FIX;
          end
        end else begin
`ifdef MULDIV_FAST_MUL_EN
          acc_d   = fast_prod;
          state_d = S_FIX;
`else
          state_d = S_CALC;
`endif
        end
      end
      S_CALC: begin
        acc_d = is_div(op_q) ? div_next : mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = fix_val;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIX);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb/tb_muldiv_iter.sv - directed checks of muldiv_iter results, latency, abort and reset
module tb_muldiv_iter;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = 35;
`endif
  localparam int DIV_LAT = 35;
  localparam int SPC_LAT = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_iter_if #(.DATA_WIDTH(32)) bus ();

  muldiv_iter #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op        = op;
    bus.operand_1 = a;
    bus.operand_2 = b;
    bus.start     = 1'b1;
  endtask

  // Edge 0 is the edge just before start is raised; lat counts edges from there
  task automatic wait_done(output int lat);
    lat = 999;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = n;
        return;
      end
    end
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    go(op, a, b);
    wait_done(lat);
    check({tag, " result"}, bus.result, exp);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic count_done(input int cycles, output int seen);
    seen = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seen++;
    end
  endtask

  initial begin
    int lat;
    int seen;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.op        = 3'b000;
    bus.operand_1 = '0;
    bus.operand_2 = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", bus.result, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    run("mulhu max", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
    run("mulh -2x3", OP_MULH, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, MUL_LAT);
    run("mul -2x3", OP_MUL, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, MUL_LAT);
    run("mulhsu -1xmax", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT);
    run("mulhu 2^16sq", OP_MULHU, 32'h00010000, 32'h00010000, 32'h00000001, MUL_LAT);

    run("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, DIV_LAT);
    run("rem -7/2", OP_REM, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, DIV_LAT);
    run("divu big/2", OP_DIVU, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, DIV_LAT);
    run("rem 7/-2", OP_REM, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, DIV_LAT);
    run("div 7/-2", OP_DIV, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT);

    run("divu 5/0", OP_DIVU, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, SPC_LAT);
    run("remu 5/0", OP_REMU, 32'h00000005, 32'h00000000, 32'h00000005, SPC_LAT);
    run("div ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPC_LAT);
    run("rem ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, SPC_LAT);
    run("rem -7/0", OP_REM, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, SPC_LAT);

    go(OP_DIV, 32'h00000064, 32'h00000007);
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    check("abort busy before", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check("abort busy after", 32'(bus.busy), 32'd0);
    count_done(50, seen);
    check("abort no done", 32'(seen), 32'd0);
    check("abort result kept", bus.result, 32'hFFFFFFF9);

    go(OP_DIVU, 32'h00000064, 32'h00000007);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start+abort busy", 32'(bus.busy), 32'd0);
    count_done(40, seen);
    check("start+abort no done", 32'(seen), 32'd0);

    go(OP_DIVU, 32'h00000064, 32'h00000007);
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    go(OP_MUL, 32'h00000003, 32'h00000003);
    wait_done(lat);
    check("busy start result", bus.result, 32'h0000000E);
    check("busy start latency", 32'(lat + 5), 32'(DIV_LAT));
    count_done(40, seen);
    check("busy start no extra done", 32'(seen), 32'd0);

    run("b2b first", OP_MUL, 32'h00000007, 32'h00000006, 32'h0000002A, MUL_LAT);
    run("b2b second", OP_REMU, 32'h00000064, 32'h00000007, 32'h00000002, DIV_LAT);

    go(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async reset busy", 32'(bus.busy), 32'd0);
    check("async reset done", 32'(bus.done), 32'd0);
    check("async reset result", bus.result, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    run("after reset", OP_DIVU, 32'h00000064, 32'h00000007, 32'h0000000E, DIV_LAT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
